// File: rtl/asynchronous_fifo_write_controller.sv
// asynchronous_fifo_write_controller: write side of an async FIFO (pointers, read-pointer CDC, full/almost_full/overflow).
// Define ASYNC_FIFO_WRITE_LEVEL_EN to add the registered write_level output.
module asynchronous_fifo_write_controller #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 4096,
  parameter int ALMOST_FULL_THRESHOLD = DATA_DEPTH - 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          write_enable,
  input  logic [DATA_WIDTH-1:0]         write_data,
  input  logic [$clog2(DATA_DEPTH)-1:0] read_pointer_gray,
  input  logic                          overflow_clear,
  output logic                          memory_write_enable,
  output logic [$clog2(DATA_DEPTH)-1:0] memory_write_address,
  output logic [DATA_WIDTH-1:0]         memory_write_data,
  output logic [$clog2(DATA_DEPTH)-1:0] write_pointer_gray,
  output logic                          full,
  output logic                          almost_full,
  output logic                          overflow
`ifdef ASYNC_FIFO_WRITE_LEVEL_EN
  ,
  output logic [$clog2(DATA_DEPTH)-1:0] write_level
`endif
);
  localparam int AW = $clog2(DATA_DEPTH);
  localparam logic [AW-1:0] AF_THRESHOLD = AW'(ALMOST_FULL_THRESHOLD);
  function automatic logic [AW-1:0] gray_to_bin(input logic [AW-1:0] g);
    logic [AW-1:0] b;
    b = g;
    for (int i = 1; i < AW; i++) b = b ^ (g >> i);
    return b;
  endfunction
  logic          accept;
  logic [AW-1:0] write_pointer_q, write_pointer_d;
  logic [AW-1:0] write_pointer_gray_q, write_pointer_gray_d;
  logic [AW-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [AW-1:0] read_pointer_next, fill_next;
  logic          full_q, full_d, almost_full_q, almost_full_d, overflow_q, overflow_d;
  // Flags are evaluated against decode(sync1), which is exactly what sync2 holds next cycle,
  // so sync2 itself has no downstream reader.
  logic          unused_sync2;
  assign unused_sync2 = ^sync2_q;
  always_comb begin
    accept               = reset_n && write_enable && !full_q;
    write_pointer_d      = write_pointer_q + AW'(accept);
    write_pointer_gray_d = write_pointer_d ^ (write_pointer_d >> 1);
    sync1_d              = read_pointer_gray;
    sync2_d              = sync1_q;
    read_pointer_next    = gray_to_bin(sync1_q);
    fill_next            = write_pointer_d - read_pointer_next;
    full_d               = (write_pointer_d + AW'(1)) == read_pointer_next;
    almost_full_d        = fill_next >= AF_THRESHOLD;
    overflow_d           = (write_enable && full_q) || (overflow_q && !overflow_clear);
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      write_pointer_q      <= '0;
      write_pointer_gray_q <= '0;
      sync1_q              <= '0;
      sync2_q              <= '0;
      full_q               <= 1'b0;
      almost_full_q        <= 1'b0;
      overflow_q           <= 1'b0;
    end else begin
      write_pointer_q      <= write_pointer_d;
      write_pointer_gray_q <= write_pointer_gray_d;
      sync1_q              <= sync1_d;
      sync2_q              <= sync2_d;
      full_q               <= full_d;
      almost_full_q        <= almost_full_d;
      overflow_q           <= overflow_d;
    end
  end
`ifdef ASYNC_FIFO_WRITE_LEVEL_EN
  logic [AW-1:0] write_level_q, write_level_d;
  assign write_level_d = fill_next;
  always_ff @(posedge clock) begin
    if (!reset_n) write_level_q <= '0;
    else write_level_q <= write_level_d;
  end
  assign write_level = write_level_q;
`endif
  assign memory_write_enable  = accept;
  assign memory_write_address = write_pointer_q;
  assign memory_write_data    = write_data;
  assign write_pointer_gray   = write_pointer_gray_q;
  assign full                 = full_q;
  assign almost_full          = almost_full_q;
  assign overflow             = overflow_q;
endmodule

// File: tb/tb_asynchronous_fifo_write_controller.sv
// tb_asynchronous_fifo_write_controller: directed vector table plus randomized run against a pointer-arithmetic model.
module tb_asynchronous_fifo_write_controller;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        write_enable = 1'b0;
  logic [15:0] write_data = '0;
  logic [2:0]  read_pointer_gray = '0;
  logic        overflow_clear = 1'b0;
  logic        memory_write_enable;
  logic [2:0]  memory_write_address;
  logic [15:0] memory_write_data;
  logic [2:0]  write_pointer_gray;
  logic        full, almost_full, overflow;
`ifdef ASYNC_FIFO_WRITE_LEVEL_EN
  logic [2:0]  write_level;
`endif
  int n_chk = 0;
  int n_fail = 0;

  asynchronous_fifo_write_controller #(
    .DATA_WIDTH(16), .DATA_DEPTH(8), .ALMOST_FULL_THRESHOLD(6)
  ) dut (
    .clock(clock), .reset_n(reset_n), .write_enable(write_enable), .write_data(write_data),
    .read_pointer_gray(read_pointer_gray), .overflow_clear(overflow_clear),
    .memory_write_enable(memory_write_enable), .memory_write_address(memory_write_address),
    .memory_write_data(memory_write_data), .write_pointer_gray(write_pointer_gray),
    .full(full), .almost_full(almost_full), .overflow(overflow)
`ifdef ASYNC_FIFO_WRITE_LEVEL_EN
    , .write_level(write_level)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n, we, oclr;
    logic [15:0] data;
    logic [2:0]  rpg;
    logic        mwe;
    logic [2:0]  addr, wpg;
    logic        full, af, ovf;
  } vec_t;

  function automatic vec_t v(input logic rst_n, we, oclr, input logic [15:0] data, input logic [2:0] rpg,
                             input logic mwe, input logic [2:0] addr, wpg, input logic f, af, ovf);
    vec_t t;
    t.rst_n = rst_n; t.we = we; t.oclr = oclr; t.data = data; t.rpg = rpg;
    t.mwe = mwe; t.addr = addr; t.wpg = wpg; t.full = f; t.af = af; t.ovf = ovf;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    @(negedge clock);
    reset_n = t.rst_n; write_enable = t.we; overflow_clear = t.oclr;
    write_data = t.data; read_pointer_gray = t.rpg;
    #1;
    chk({tag, ".mwe"}, memory_write_enable, t.mwe);
    if (t.mwe) begin
      chk({tag, ".addr"}, memory_write_address, t.addr);
      chk({tag, ".data"}, memory_write_data, t.data);
    end
    @(posedge clock);
    #1;
    chk({tag, ".wpg"}, write_pointer_gray, t.wpg);
    chk({tag, ".full"}, full, t.full);
    chk({tag, ".af"}, almost_full, t.af);
    chk({tag, ".ovf"}, overflow, t.ovf);
  endtask

  vec_t tbl[$];
  int mwp, mrp, rp_seen, fill;
  logic mfull, maf, movf, we, oc, acc;
  logic [15:0] d;

  initial begin
    // rst_n we oclr data rpg | mwe addr wpg full af ovf
    tbl.push_back(v(0, 1, 0, 16'h0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 16'h0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 16'h1,  0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 16'h2,  0, 1, 1, 3, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 16'h3,  0, 1, 2, 2, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 16'h4,  0, 1, 3, 6, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 16'h5,  0, 1, 4, 7, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 16'h6,  0, 1, 5, 5, 0, 1, 0));
    tbl.push_back(v(1, 1, 0, 16'h7,  0, 1, 6, 4, 1, 1, 0));
    tbl.push_back(v(1, 1, 0, 16'h8,  0, 0, 0, 4, 1, 1, 1));
    tbl.push_back(v(1, 1, 0, 16'h9,  0, 0, 0, 4, 1, 1, 1));
    tbl.push_back(v(1, 0, 0, 16'h0,  2, 0, 0, 4, 1, 1, 1));
    tbl.push_back(v(1, 0, 0, 16'h0,  2, 0, 0, 4, 0, 0, 1));
    tbl.push_back(v(1, 1, 0, 16'hA,  2, 1, 7, 0, 0, 0, 1));
    tbl.push_back(v(1, 1, 0, 16'hB,  2, 1, 0, 1, 0, 1, 1));
    tbl.push_back(v(1, 1, 0, 16'hC,  2, 1, 1, 3, 1, 1, 1));
    tbl.push_back(v(1, 0, 1, 16'h0,  2, 0, 0, 3, 1, 1, 0));
    tbl.push_back(v(1, 1, 1, 16'hD,  2, 0, 0, 3, 1, 1, 1));
    tbl.push_back(v(1, 1, 0, 16'h55, 6, 0, 0, 3, 1, 1, 1));
    tbl.push_back(v(1, 0, 0, 16'h0,  6, 0, 0, 3, 0, 1, 1));
    tbl.push_back(v(1, 1, 0, 16'hAA, 6, 1, 2, 2, 1, 1, 1));
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // reset in the middle of traffic: pointer restarts at address 0
    apply(v(0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0), "mid.rst0");
    for (int i = 0; i < 4; i++)
      apply(v(1, 1, 0, 16'h100 + 16'(i), 0, 1, 3'(i), 3'((i + 1) ^ ((i + 1) >> 1)), 0, 0, 0), $sformatf("mid.w%0d", i));
    apply(v(0, 1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0), "mid.rst1");
    apply(v(1, 1, 0, 16'h77, 0, 1, 0, 1, 0, 0, 0), "mid.first");

    // randomized traffic against an integer pointer model
    apply(v(0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0), "rnd.rst");
    mwp = 0; mrp = 0; rp_seen = 0; mfull = 0; maf = 0; movf = 0;
    for (int k = 0; k < 400; k++) begin
      we = $urandom_range(3) != 0;
      oc = $urandom_range(7) == 0;
      d = 16'($urandom);
      if (mrp != mwp && $urandom_range(2) == 0) mrp = (mrp + 1) % 8;
      @(negedge clock);
      reset_n = 1; write_enable = we; overflow_clear = oc; write_data = d;
      read_pointer_gray = 3'(mrp ^ (mrp >> 1));
      #1;
      acc = we && !mfull;
      chk("rnd.mwe", memory_write_enable, acc);
      if (acc) begin
        chk("rnd.addr", memory_write_address, mwp);
        chk("rnd.data", memory_write_data, d);
      end
      @(posedge clock);
      if (acc) mwp = (mwp + 1) % 8;
      movf = (we && mfull) || (movf && !oc);
      mfull = ((mwp + 1) % 8) == rp_seen;
      fill = (mwp - rp_seen + 8) % 8;
      maf = fill >= 6;
      rp_seen = mrp;
      #1;
      chk("rnd.wpg", write_pointer_gray, mwp ^ (mwp >> 1));
      chk("rnd.full", full, mfull);
      chk("rnd.af", almost_full, maf);
      chk("rnd.ovf", overflow, movf);
`ifdef ASYNC_FIFO_WRITE_LEVEL_EN
      chk("rnd.level", write_level, fill);
`endif
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
